// File: rtl/relu_fix.sv
// Combinational fixed-point ReLU: negative words clamp to zero, others pass through.
module relu_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = din[WIDTH-1] ? '0 : din;

endmodule

// File: rtl/relu_layer_seq.sv
// Streams one layer of accumulator words through ReLU (or bypass) into the activation
// memory, using a 2-entry skid FIFO so back-pressure never drops a read response.
module relu_layer_seq #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] n_neurons,
  input  logic              bypass,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] neg_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] FIFO_SLOTS = 3'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] n_lat;
  logic              bypass_lat;
  logic [ADDR_W-1:0] rd_idx;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_idx;

  logic [WIDTH-1:0]  fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic              head;
  logic              tail;
  logic [1:0]        fifo_cnt;

  logic              pop;
  logic [2:0]        occ;
  logic [WIDTH-1:0]  relu_out;
  logic [WIDTH-1:0]  push_data;

  relu_fix #(.WIDTH(WIDTH)) u_relu (
    .din  (rd_data),
    .dout (relu_out)
  );

  assign push_data = bypass_lat ? rd_data : relu_out;
  assign pop       = wr_valid && wr_ready;

  // Slots committed after this edge: buffered + the read already on the bus - the one leaving.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en = (state == RUN) && !abort && (rd_idx < n_lat) && (occ < FIFO_SLOTS);

  assign rd_addr  = rd_idx;
  assign wr_valid = (fifo_cnt != 2'd0);
  assign wr_data  = fifo_data[head];
  assign wr_addr  = fifo_addr[head];
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n_lat        <= '0;
      bypass_lat   <= 1'b0;
      rd_idx       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      head         <= 1'b0;
      tail         <= 1'b0;
      fifo_cnt     <= 2'd0;
      neg_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat      <= n_neurons;
            bypass_lat <= bypass;
            neg_count  <= '0;
            rd_idx     <= '0;
            state      <= (n_neurons == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            // The read already issued is simply never pushed.
            state    <= IDLE;
            inflight <= 1'b0;
            fifo_cnt <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
          end else begin
            inflight     <= rd_en;
            inflight_idx <= rd_idx;
            if (rd_en) rd_idx <= rd_idx + 1'b1;
            if (inflight) begin
              fifo_data[tail] <= push_data;
              fifo_addr[tail] <= inflight_idx;
              tail            <= ~tail;
              if (rd_data[WIDTH-1]) neg_count <= neg_count + 1'b1;
            end
            if (pop) head <= ~head;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
            if (pop && (wr_addr == n_lat - 1'b1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
